// File: rtl/cpu_reset_sequencer.sv
// cpu_reset_sequencer: drives a programmable train of reset pulses into the
// cpu, then supervises the run phase with a halt-or-timeout watchdog.
// Extra pulses may be requested externally during GAP/RUN. All outputs are
// registered; status flags are sticky until this block is reset.
module cpu_reset_sequencer #(
  parameter int NUM_PULSES  = 2,
  parameter int FIRST_DELAY = 1,
  parameter int PULSE_WIDTH = 3,
  parameter int GAP_CYCLES  = 50,
  parameter int RUN_CYCLES  = 100,
  parameter int CW          = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          halt,
  input  logic          ext_rst_req,
  output logic          cpu_reset,
  output logic [2:0]    phase,
  output logic [7:0]    pulse_count,
  output logic [7:0]    ext_count,
  output logic [CW-1:0] cycle_count,
  output logic          done,
  output logic          pass,
  output logic          timeout
);

  // Interval counter is sized to the longest programmed interval so that a
  // narrow CW (cycle_count only) cannot truncate the timing.
  localparam int M_A   = (FIRST_DELAY > PULSE_WIDTH) ? FIRST_DELAY : PULSE_WIDTH;
  localparam int M_B   = (GAP_CYCLES > RUN_CYCLES) ? GAP_CYCLES : RUN_CYCLES;
  localparam int MAXP  = (M_A > M_B) ? M_A : M_B;
  localparam int CNT_W = $clog2(MAXP + 1);
  localparam int SW    = (NUM_PULSES > 1) ? $clog2(NUM_PULSES) : 1;
  localparam int NP_L  = (NUM_PULSES > 0) ? NUM_PULSES - 1 : 0;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] FD_V    = CNT_W'(FIRST_DELAY);
  localparam logic [CNT_W-1:0] PW_M1   = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] GAP_M1  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_M1  = CNT_W'(RUN_CYCLES - 1);
  localparam logic [SW-1:0]    SCH_ONE = SW'(1);
  localparam logic [SW-1:0]    NP_LAST = SW'(NP_L);
  localparam logic [CW-1:0]    CC_ONE  = CW'(1);
  localparam logic [CW-1:0]    CC_MAX  = {CW{1'b1}};

  typedef enum logic [2:0] {
    S_DELAY  = 3'd0,
    S_PULSE  = 3'd1,
    S_GAP    = 3'd2,
    S_RUN    = 3'd3,
    S_XPULSE = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [SW-1:0]    r_sched;
  logic             r_cpu_reset;
  logic [7:0]       r_pulse_count;
  logic [7:0]       r_ext_count;
  logic [CW-1:0]    r_cycle_count;
  logic             r_done;
  logic             r_pass;
  logic             r_timeout;

  // Free-running, saturating cycle counter since reset release.
  always_ff @(posedge clk) begin
    if (!reset)
      r_cycle_count <= '0;
    else if (r_cycle_count != CC_MAX)
      r_cycle_count <= r_cycle_count + CC_ONE;
  end

  // Sequencer FSM; cpu_reset and status are registered alongside the state
  // so every output changes on the same edge as phase.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_DELAY;
      r_cnt         <= '0;
      r_sched       <= '0;
      r_cpu_reset   <= 1'b0;
      r_pulse_count <= '0;
      r_ext_count   <= '0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      case (r_state)
        // The reset-release edge itself counts, hence compare against FD.
        S_DELAY: begin
          if (r_cnt == FD_V) begin
            r_cnt <= '0;
            if (NUM_PULSES > 0) begin
              r_state     <= S_PULSE;
              r_cpu_reset <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        S_PULSE: begin
          if (r_cnt == PW_M1) begin
            r_cnt       <= '0;
            r_cpu_reset <= 1'b0;
            if (r_pulse_count != 8'hFF)
              r_pulse_count <= r_pulse_count + 8'd1;
            if (r_sched == NP_LAST) begin
              r_state <= S_RUN;
            end else begin
              r_sched <= r_sched + SCH_ONE;
              r_state <= S_GAP;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        // An external request pre-empts the next scheduled pulse.
        S_GAP: begin
          if (ext_rst_req) begin
            r_state     <= S_XPULSE;
            r_cpu_reset <= 1'b1;
            r_cnt       <= '0;
          end else if (r_cnt == GAP_M1) begin
            r_state     <= S_PULSE;
            r_cpu_reset <= 1'b1;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        // Priority: halt, then external request, then watchdog expiry.
        S_RUN: begin
          if (halt) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_pass  <= 1'b1;
          end else if (ext_rst_req) begin
            r_state     <= S_XPULSE;
            r_cpu_reset <= 1'b1;
            r_cnt       <= '0;
          end else if (r_cnt == RUN_M1) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        // Extra pulse always returns to a fresh watchdog window.
        S_XPULSE: begin
          if (r_cnt == PW_M1) begin
            r_state     <= S_RUN;
            r_cpu_reset <= 1'b0;
            r_cnt       <= '0;
            if (r_ext_count != 8'hFF)
              r_ext_count <= r_ext_count + 8'd1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        S_DONE: begin
          r_cpu_reset <= 1'b0;
        end

        default: begin
          r_state     <= S_DELAY;
          r_cnt       <= '0;
          r_cpu_reset <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_reset   = r_cpu_reset;
  assign phase       = r_state;
  assign pulse_count = r_pulse_count;
  assign ext_count   = r_ext_count;
  assign cycle_count = r_cycle_count;
  assign done        = r_done;
  assign pass        = r_pass;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_cpu_reset_sequencer.sv
// Bench for cpu_reset_sequencer: three configurations (defaults, no pulses,
// narrow cycle counter with short intervals) driven with shared stimulus and
// compared each cycle against a timeline model derived from the parameters.
module tb_cpu_reset_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic halt = 1'b0;
  logic ext_rst_req = 1'b0;

  always #5 clk = ~clk;

  // Configuration table: d=0 defaults, d=1 no pulses, d=2 CW=4 short.
  int C_NP  [3] = '{2, 0, 3};
  int C_FD  [3] = '{1, 1, 2};
  int C_PW  [3] = '{3, 3, 2};
  int C_GAP [3] = '{50, 50, 3};
  int C_RUN [3] = '{100, 100, 6};
  int C_CW  [3] = '{16, 16, 4};

  logic        cpu_o [3];
  logic [2:0]  ph_o  [3];
  logic [7:0]  pc_o  [3];
  logic [7:0]  xc_o  [3];
  logic [15:0] cc_o  [3];
  logic        dn_o  [3];
  logic        ps_o  [3];
  logic        to_o  [3];
  logic [15:0] cc0, cc1;
  logic [3:0]  cc2;

  assign cc_o[0] = cc0;
  assign cc_o[1] = cc1;
  assign cc_o[2] = {12'd0, cc2};

  cpu_reset_sequencer u0 (
    .clk(clk), .reset(reset), .halt(halt), .ext_rst_req(ext_rst_req),
    .cpu_reset(cpu_o[0]), .phase(ph_o[0]), .pulse_count(pc_o[0]),
    .ext_count(xc_o[0]), .cycle_count(cc0), .done(dn_o[0]),
    .pass(ps_o[0]), .timeout(to_o[0]));

  cpu_reset_sequencer #(.NUM_PULSES(0)) u1 (
    .clk(clk), .reset(reset), .halt(halt), .ext_rst_req(ext_rst_req),
    .cpu_reset(cpu_o[1]), .phase(ph_o[1]), .pulse_count(pc_o[1]),
    .ext_count(xc_o[1]), .cycle_count(cc1), .done(dn_o[1]),
    .pass(ps_o[1]), .timeout(to_o[1]));

  cpu_reset_sequencer #(.NUM_PULSES(3), .FIRST_DELAY(2), .PULSE_WIDTH(2),
                        .GAP_CYCLES(3), .RUN_CYCLES(6), .CW(4)) u2 (
    .clk(clk), .reset(reset), .halt(halt), .ext_rst_req(ext_rst_req),
    .cpu_reset(cpu_o[2]), .phase(ph_o[2]), .pulse_count(pc_o[2]),
    .ext_count(xc_o[2]), .cycle_count(cc2), .done(dn_o[2]),
    .pass(ps_o[2]), .timeout(to_o[2]));

  int total = 0;
  int bad = 0;

  // First RUN cycle of the undisturbed schedule.
  function automatic int run0(int c);
    if (C_NP[c] == 0) return C_FD[c];
    return C_FD[c] + C_NP[c] * C_PW[c] + (C_NP[c] - 1) * C_GAP[c];
  endfunction

  // Phase of the undisturbed schedule at cycle t (before any DONE).
  function automatic int base_phase(int c, int t);
    int off;
    if (t < C_FD[c]) return 0;
    if (t >= run0(c)) return 3;
    off = (t - C_FD[c]) % (C_PW[c] + C_GAP[c]);
    return (off < C_PW[c]) ? 1 : 2;
  endfunction

  // Scheduled pulses completed as seen at cycle t.
  function automatic int pulses_by(int c, int t);
    int n = 0;
    for (int i = 0; i < C_NP[c]; i++)
      if (C_FD[c] + i * (C_PW[c] + C_GAP[c]) + C_PW[c] <= t) n++;
    return n;
  endfunction

  // Expected outputs at cycle k given one ext request at e and one halt at h
  // (-1 = never).
  function automatic void model(input int c, input int k, input int e, input int h,
                                output int ph, output int cpu, output int pc,
                                output int xc, output int cc, output int dn,
                                output int ps, output int to);
    int r0, rs, re, dat, bpe;
    bit ext_ok, hok;
    r0  = run0(c);
    bpe = (e >= 0) ? base_phase(c, e) : 0;
    ext_ok = (e >= 0) && (bpe == 2 || (bpe == 3 && e <= r0 + C_RUN[c] - 1))
             && !(h >= r0 && h <= e);
    rs  = ext_ok ? e + C_PW[c] + 1 : r0;
    re  = rs + C_RUN[c] - 1;
    hok = (h >= rs) && (h <= re);
    dat = hok ? h + 1 : re + 1;
    cc  = (k + 1 < (1 << C_CW[c])) ? k + 1 : (1 << C_CW[c]) - 1;
    if (k >= dat) begin
      ph = 5; dn = 1; ps = hok ? 1 : 0; to = hok ? 0 : 1;
    end else begin
      dn = 0; ps = 0; to = 0;
      if (ext_ok && k > e) ph = (k < rs) ? 4 : 3;
      else                 ph = base_phase(c, k);
    end
    cpu = (ph == 1 || ph == 4) ? 1 : 0;
    pc  = pulses_by(c, (ext_ok && k > e) ? e : k);
    xc  = (ext_ok && k >= rs) ? 1 : 0;
  endfunction

  // Releases reset, runs n cycles with ext at e / halt at h, checking every
  // cycle of every instance, then puts the DUTs back into reset.
  task automatic test_sequence(input string nm, input int e, input int h, input int n);
    int ph, cpu, pc, xc, cc, dn, ps, to;
    @(negedge clk);
    reset = 1'b1; halt = 1'b0; ext_rst_req = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        model(d, k, e, h, ph, cpu, pc, xc, cc, dn, ps, to);
        total += 8;
        if (ph_o[d] !== 3'(ph)) begin bad++;
          $display("FAIL %s u%0d cyc%0d phase got %0d want %0d", nm, d, k, ph_o[d], ph); end
        if (cpu_o[d] !== 1'(cpu)) begin bad++;
          $display("FAIL %s u%0d cyc%0d cpu_reset got %0b want %0d", nm, d, k, cpu_o[d], cpu); end
        if (pc_o[d] !== 8'(pc)) begin bad++;
          $display("FAIL %s u%0d cyc%0d pulse_count got %0d want %0d", nm, d, k, pc_o[d], pc); end
        if (xc_o[d] !== 8'(xc)) begin bad++;
          $display("FAIL %s u%0d cyc%0d ext_count got %0d want %0d", nm, d, k, xc_o[d], xc); end
        if (cc_o[d] !== 16'(cc)) begin bad++;
          $display("FAIL %s u%0d cyc%0d cycle_count got %0d want %0d", nm, d, k, cc_o[d], cc); end
        if (dn_o[d] !== 1'(dn)) begin bad++;
          $display("FAIL %s u%0d cyc%0d done got %0b want %0d", nm, d, k, dn_o[d], dn); end
        if (ps_o[d] !== 1'(ps)) begin bad++;
          $display("FAIL %s u%0d cyc%0d pass got %0b want %0d", nm, d, k, ps_o[d], ps); end
        if (to_o[d] !== 1'(to)) begin bad++;
          $display("FAIL %s u%0d cyc%0d timeout got %0b want %0d", nm, d, k, to_o[d], to); end
      end
      halt        = (k == h);
      ext_rst_req = (k == e);
    end
    reset = 1'b0; halt = 1'b0; ext_rst_req = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      total += 3;
      if (ph_o[d] !== 3'd0 || cpu_o[d] !== 1'b0) begin bad++;
        $display("FAIL reset u%0d phase/cpu got %0d/%0b want 0/0", d, ph_o[d], cpu_o[d]); end
      if (pc_o[d] !== 8'd0 || xc_o[d] !== 8'd0 || cc_o[d] !== 16'd0) begin bad++;
        $display("FAIL reset u%0d counters got %0d/%0d/%0d want 0/0/0", d, pc_o[d], xc_o[d], cc_o[d]); end
      if ({dn_o[d], ps_o[d], to_o[d]} !== 3'b000) begin bad++;
        $display("FAIL reset u%0d flags got %b want 000", d, {dn_o[d], ps_o[d], to_o[d]}); end
    end
  endtask

  task automatic test_timeout();      test_sequence("timeout", -1, -1, 170); endtask
  task automatic test_halt();         test_sequence("halt80", -1, 80, 100); endtask
  task automatic test_halt_expiry();  test_sequence("halt156", -1, 156, 170); endtask
  task automatic test_ext();          test_sequence("ext70", 70, -1, 185); endtask

  // Reset sampled low at edge 2, in the middle of the first pulse.
  task automatic test_mid_reset();
    test_sequence("mid_pre", -1, -1, 2);
    #1;
    for (int d = 0; d < 3; d++) begin
      total += 2;
      if (ph_o[d] !== 3'd0 || cpu_o[d] !== 1'b0 || dn_o[d] !== 1'b0) begin bad++;
        $display("FAIL mid_reset u%0d phase/cpu/done got %0d/%0b/%0b want 0/0/0",
                 d, ph_o[d], cpu_o[d], dn_o[d]); end
      if (pc_o[d] !== 8'd0 || cc_o[d] !== 16'd0) begin bad++;
        $display("FAIL mid_reset u%0d pulse/cycle got %0d/%0d want 0/0", d, pc_o[d], cc_o[d]); end
    end
    test_sequence("mid_replay", -1, -1, 170);
  endtask

  task automatic test_random();
    int e, h;
    for (int i = 0; i < 8; i++) begin
      e = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 200));
      h = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 280));
      test_sequence("random", e, h, 320);
    end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_halt();
    test_halt_expiry();
    test_ext();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
